// File: rtl/wishbone_mailbox_slave.sv
// ---------------------------------------------------------------------------
// wishbone_mailbox_slave
//
// Purpose:
//   Wishbone classic slave that lets a host CPU exchange 32-bit words with a
//   local streaming peripheral. The host writes words into a TX FIFO that the
//   local side drains, and reads words from an RX FIFO that the local side
//   fills. A control register enables a level interrupt, and a status
//   register reports FIFO occupancy. Each strobe assertion produces exactly
//   one access, acknowledged one cycle later for exactly one cycle.
//
// Register map (wbs_adr_i[1:0]):
//   0 CONTROL  bit0 rx_int_en, bit1 tx_int_en (RW)
//              bit2 tx_flush, bit3 rx_flush (write-only, self-clearing)
//   1 STATUS   bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full,
//              [15:8] rx_count, [23:16] tx_count (RO)
//   2 DATA     write pushes into TX, read pops RX (0 when RX empty)
//   3 reserved
//
// Optional feature macro: WB_MAILBOX_ERR_EN
//   Adds sticky STATUS bit4 tx_overflow and bit5 rx_underflow, cleared by
//   writing 1 to CONTROL bit4/bit5, and CONTROL bit6 err_int_en which folds
//   the error flags into the interrupt.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   wbs_*       Wishbone slave port (we, cyc, stb, adr, dat_i, dat_o, ack)
//   wbs_int_o   registered level interrupt
//   tx_valid_o  TX FIFO not empty
//   tx_data_o   TX FIFO head word, 0 when empty
//   tx_ready_i  local consumer accepts TX head
//   rx_valid_i  local producer offers rx_data_i
//   rx_data_i   local word to push into RX
//   rx_ready_o  RX FIFO not full
//
// Parameters:
//   DEPTH_BITS  log2 of each FIFO depth, legal range 1..7
// ---------------------------------------------------------------------------
module wishbone_mailbox_slave #(
  parameter int DEPTH_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_int_o,
  output logic        tx_valid_o,
  output logic [31:0] tx_data_o,
  input  logic        tx_ready_i,
  input  logic        rx_valid_i,
  input  logic [31:0] rx_data_i,
  output logic        rx_ready_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;

  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        int_q, int_d;

  logic        rx_int_en_q, rx_int_en_d;
  logic        tx_int_en_q, tx_int_en_d;

  logic [31:0]           tx_mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [DEPTH_BITS-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0]         tx_count_q, tx_count_d;

  logic [31:0]           rx_mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [DEPTH_BITS-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]         rx_count_q, rx_count_d;

`ifdef WB_MAILBOX_ERR_EN
  logic tx_ovf_q, tx_ovf_d;
  logic rx_unf_q, rx_unf_d;
  logic err_int_en_q, err_int_en_d;
`endif

  logic        req;
  logic        access;
  logic        wr_ctrl;
  logic        wr_data;
  logic        rd_data;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, tx_flush;
  logic        rx_push, rx_pop, rx_flush;
  logic [31:0] rx_head;
  logic [31:0] ctrl_word;
  logic [31:0] status_word;
  logic [31:0] rd_word;

  // Only the two low address bits select a register; the rest are ignored.
  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[31:2];

  assign req = wbs_cyc_i & wbs_stb_i;

  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == CNT_FULL);
  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == CNT_FULL);

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_empty ? 32'h0 : tx_mem_q[tx_rd_ptr_q];
  assign rx_ready_o = ~rx_full;
  assign rx_head    = rx_mem_q[rx_rd_ptr_q];

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign wbs_int_o = int_q;

  // Bus FSM: the access itself happens only on the IDLE edge, so a strobe
  // held high through ACK and HOLD can never trigger a second access.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          access  = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = req ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access decode derived from the one-shot access strobe.
  always_comb begin
    wr_ctrl = access &  wbs_we_i & (wbs_adr_i[1:0] == 2'd0);
    wr_data = access &  wbs_we_i & (wbs_adr_i[1:0] == 2'd2);
    rd_data = access & ~wbs_we_i & (wbs_adr_i[1:0] == 2'd2);
  end

  // FIFO handshakes. A full FIFO refuses a push even when it pops on the same
  // edge, which falls out of gating the push on the current full flag.
  always_comb begin
    tx_push  = wr_data & ~tx_full;
    tx_pop   = tx_valid_o & tx_ready_i;
    tx_flush = wr_ctrl & wbs_dat_i[2];
    rx_push  = rx_valid_i & rx_ready_o;
    rx_pop   = rd_data & ~rx_empty;
    rx_flush = wr_ctrl & wbs_dat_i[3];
  end

  // TX FIFO pointers and count; a flush overrides any push/pop this edge.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_d = tx_count_q + CNT_ONE;
        2'b01:   tx_count_d = tx_count_q - CNT_ONE;
        default: tx_count_d = tx_count_q;
      endcase
    end
  end

  // RX FIFO pointers and count; a flush overrides any push/pop this edge.
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_flush) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_d = rx_count_q + CNT_ONE;
        2'b01:   rx_count_d = rx_count_q - CNT_ONE;
        default: rx_count_d = rx_count_q;
      endcase
    end
  end

  // Control register and error flags. For the error flags the set term is
  // applied after the clear so a coincident set wins.
  always_comb begin
    rx_int_en_d = rx_int_en_q;
    tx_int_en_d = tx_int_en_q;
    if (wr_ctrl) begin
      rx_int_en_d = wbs_dat_i[0];
      tx_int_en_d = wbs_dat_i[1];
    end
`ifdef WB_MAILBOX_ERR_EN
    err_int_en_d = err_int_en_q;
    tx_ovf_d     = tx_ovf_q;
    rx_unf_d     = rx_unf_q;
    if (wr_ctrl) begin
      err_int_en_d = wbs_dat_i[6];
      if (wbs_dat_i[4]) tx_ovf_d = 1'b0;
      if (wbs_dat_i[5]) rx_unf_d = 1'b0;
    end
    if (wr_data & tx_full)  tx_ovf_d = 1'b1;
    if (rd_data & rx_empty) rx_unf_d = 1'b1;
`endif
  end

  // Read-back words and the registered read data / interrupt.
  always_comb begin
    ctrl_word          = 32'h0;
    ctrl_word[0]       = rx_int_en_q;
    ctrl_word[1]       = tx_int_en_q;
    status_word        = 32'h0;
    status_word[0]     = rx_empty;
    status_word[1]     = rx_full;
    status_word[2]     = tx_empty;
    status_word[3]     = tx_full;
    status_word[15:8]  = 8'(rx_count_q);
    status_word[23:16] = 8'(tx_count_q);
    int_d = (rx_int_en_q & ~rx_empty) | (tx_int_en_q & tx_empty);
`ifdef WB_MAILBOX_ERR_EN
    ctrl_word[6]   = err_int_en_q;
    status_word[4] = tx_ovf_q;
    status_word[5] = rx_unf_q;
    int_d = int_d | (err_int_en_q & (tx_ovf_q | rx_unf_q));
`endif
    case (wbs_adr_i[1:0])
      2'd0:    rd_word = ctrl_word;
      2'd1:    rd_word = status_word;
      2'd2:    rd_word = rx_empty ? 32'h0 : rx_head;
      default: rd_word = 32'h0;
    endcase
    dat_d = (access & ~wbs_we_i) ? rd_word : 32'h0;
  end

  // FIFO storage carries no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= wbs_dat_i;
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data_i;
  end

  // State register for the FSM, bus outputs, control and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      int_q       <= 1'b0;
      rx_int_en_q <= 1'b0;
      tx_int_en_q <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
`ifdef WB_MAILBOX_ERR_EN
      tx_ovf_q     <= 1'b0;
      rx_unf_q     <= 1'b0;
      err_int_en_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      int_q       <= int_d;
      rx_int_en_q <= rx_int_en_d;
      tx_int_en_q <= tx_int_en_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
`ifdef WB_MAILBOX_ERR_EN
      tx_ovf_q     <= tx_ovf_d;
      rx_unf_q     <= rx_unf_d;
      err_int_en_q <= err_int_en_d;
`endif
    end
  end

endmodule

// File: tb/tb_wishbone_mailbox_slave.sv
// ---------------------------------------------------------------------------
// tb_wishbone_mailbox_slave
//
// Self-checking bench for wishbone_mailbox_slave built with DEPTH_BITS=2 so
// the full-FIFO corners are reached quickly. A queue-based model of the two
// FIFOs and the control bits predicts every register read, handshake flag
// and the interrupt level. Honours WB_MAILBOX_ERR_EN the same way the design
// does.
// ---------------------------------------------------------------------------
module tb_wishbone_mailbox_slave;

  localparam int DB    = 2;
  localparam int DEPTH = 1 << DB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_int_o;
  logic        tx_valid_o;
  logic [31:0] tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [31:0] rx_data_i = 32'h0;
  logic        rx_ready_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        m_rx_int_en = 1'b0;
  logic        m_tx_int_en = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic        m_err_int_en = 1'b0;

  wishbone_mailbox_slave #(.DEPTH_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .wbs_we_i   (wbs_we_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_int_o  (wbs_int_o),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled on the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (rx_q.size() == 0);
    s[1]     = (rx_q.size() == DEPTH);
    s[2]     = (tx_q.size() == 0);
    s[3]     = (tx_q.size() == DEPTH);
    s[15:8]  = 8'(rx_q.size());
    s[23:16] = 8'(tx_q.size());
`ifdef WB_MAILBOX_ERR_EN
    s[4] = m_ovf;
    s[5] = m_unf;
`endif
    return s;
  endfunction

  function automatic logic [31:0] modelControl();
    logic [31:0] c;
    c    = 32'h0;
    c[0] = m_rx_int_en;
    c[1] = m_tx_int_en;
`ifdef WB_MAILBOX_ERR_EN
    c[6] = m_err_int_en;
`endif
    return c;
  endfunction

  function automatic logic modelInt();
    logic v;
    v = (m_rx_int_en && rx_q.size() != 0) || (m_tx_int_en && tx_q.size() == 0);
`ifdef WB_MAILBOX_ERR_EN
    v = v || (m_err_int_en && (m_ovf || m_unf));
`endif
    return v;
  endfunction

  task automatic modelReset();
    tx_q.delete();
    rx_q.delete();
    m_rx_int_en  = 1'b0;
    m_tx_int_en  = 1'b0;
    m_ovf        = 1'b0;
    m_unf        = 1'b0;
    m_err_int_en = 1'b0;
  endtask

  // One complete single Wishbone access: predicts the result, drives the
  // strobe for one cycle, checks ack timing, read data and interrupt.
  task automatic applyStimulus(input logic we, input logic [1:0] a,
                               input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [31:0] r;
    exp_rd = 32'h0;
    if (!we) begin
      case (a)
        2'd0: exp_rd = modelControl();
        2'd1: exp_rd = modelStatus();
        2'd2: begin
          if (rx_q.size() != 0) exp_rd = rx_q.pop_front();
          else m_unf = 1'b1;
        end
        default: exp_rd = 32'h0;
      endcase
    end else begin
      case (a)
        2'd0: begin
          m_rx_int_en = d[0];
          m_tx_int_en = d[1];
          if (d[2]) tx_q.delete();
          if (d[3]) rx_q.delete();
`ifdef WB_MAILBOX_ERR_EN
          if (d[4]) m_ovf = 1'b0;
          if (d[5]) m_unf = 1'b0;
          m_err_int_en = d[6];
`endif
        end
        2'd2: begin
          if (tx_q.size() < DEPTH) tx_q.push_back(d);
          else m_ovf = 1'b1;
        end
        default: ;
      endcase
    end
    r = $urandom();
    wbs_adr_i = {r[31:2], a};
    wbs_we_i  = we;
    wbs_dat_i = d;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    tick();
    checkOutput("ack_high", {31'b0, wbs_ack_o}, 32'h1);
    checkOutput(we ? "wr_dat_o" : "rd_data", wbs_dat_o, exp_rd);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    tick();
    checkOutput("ack_low", {31'b0, wbs_ack_o}, 32'h0);
    checkOutput("int_after_bus", {31'b0, wbs_int_o}, {31'b0, modelInt()});
  endtask

  task automatic localRxPush(input logic [31:0] d);
    checkOutput("rx_ready", {31'b0, rx_ready_o}, {31'b0, (rx_q.size() < DEPTH)});
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    tick();
    rx_valid_i = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(d);
    tick();
    checkOutput("int_after_rx", {31'b0, wbs_int_o}, {31'b0, modelInt()});
  endtask

  task automatic localTxPop();
    logic [31:0] exp_head;
    exp_head = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
    checkOutput("tx_valid", {31'b0, tx_valid_o}, {31'b0, (tx_q.size() != 0)});
    checkOutput("tx_data", tx_data_o, exp_head);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
    tick();
    checkOutput("int_after_tx", {31'b0, wbs_int_o}, {31'b0, modelInt()});
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] words [5];
    logic [31:0] held_data;
    int          ack_count;
    int          first_ack;

    // Power-on reset
    @(negedge clk);
    checkOutput("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    checkOutput("rst_int", {31'b0, wbs_int_o}, 32'h0);
    checkOutput("rst_tx_valid", {31'b0, tx_valid_o}, 32'h0);
    checkOutput("rst_rx_ready", {31'b0, rx_ready_o}, 32'h1);
    tick();
    rst = 1'b1;
    tick();

    // Reset asserted while ack is high drops ack at once and empties FIFOs
    applyStimulus(1'b1, 2'd2, 32'h11111111, rd);
    checkOutput("tx_valid_one", {31'b0, tx_valid_o}, 32'h1);
    wbs_adr_i = 32'h1;
    wbs_we_i  = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midack_ack_high", {31'b0, wbs_ack_o}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("midack_ack_drop", {31'b0, wbs_ack_o}, 32'h0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    tick();
    applyStimulus(1'b0, 2'd1, 32'h0, rd);
    checkOutput("status_after_rst", rd, 32'h00000005);
    checkOutput("rx_ready_after_rst", {31'b0, rx_ready_o}, 32'h1);
    checkOutput("tx_valid_after_rst", {31'b0, tx_valid_o}, 32'h0);
    checkOutput("tx_data_after_rst", tx_data_o, 32'h0);

    // TX path ordering
    applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, rd);
    applyStimulus(1'b1, 2'd2, 32'h12345678, rd);
    applyStimulus(1'b0, 2'd1, 32'h0, rd);
    checkOutput("tx_count_two", {24'b0, rd[23:16]}, 32'h2);
    tx_ready_i = 1'b1;
    checkOutput("tx_first", tx_data_o, 32'hDEADBEEF);
    tick();
    checkOutput("tx_second", tx_data_o, 32'h12345678);
    tick();
    checkOutput("tx_drained", {31'b0, tx_valid_o}, 32'h0);
    tx_ready_i = 1'b0;
    void'(tx_q.pop_front());
    void'(tx_q.pop_front());

    // TX full: fifth word is lost
    for (int i = 0; i < 5; i++) begin
      words[i] = $urandom();
      applyStimulus(1'b1, 2'd2, words[i], rd);
    end
    applyStimulus(1'b0, 2'd1, 32'h0, rd);
    checkOutput("tx_full_flag", {31'b0, rd[3]}, 32'h1);
    checkOutput("tx_full_count", {24'b0, rd[23:16]}, 32'h4);
`ifdef WB_MAILBOX_ERR_EN
    checkOutput("tx_ovf_set", {31'b0, rd[4]}, 32'h1);
    applyStimulus(1'b1, 2'd0, 32'h10, rd);
    applyStimulus(1'b0, 2'd1, 32'h0, rd);
    checkOutput("tx_ovf_clear", {31'b0, rd[4]}, 32'h0);
`endif
    for (int i = 0; i < 4; i++) begin
      checkOutput("tx_full_order", tx_data_o, words[i]);
      localTxPop();
    end
    checkOutput("tx_fifth_lost", {31'b0, tx_valid_o}, 32'h0);

    // RX path and interrupt
    applyStimulus(1'b1, 2'd0, 32'h1, rd);
    localRxPush(32'hA5A5A5A5);
    checkOutput("rx_int_set", {31'b0, wbs_int_o}, 32'h1);
    applyStimulus(1'b0, 2'd2, 32'h0, rd);
    checkOutput("rx_word", rd, 32'hA5A5A5A5);
    checkOutput("rx_int_clear", {31'b0, wbs_int_o}, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h0, rd);
    checkOutput("rx_empty_read", rd, 32'h0);

    // RX full: the extra word is refused
    for (int i = 0; i < DEPTH + 1; i++) localRxPush($urandom());
    checkOutput("rx_ready_full", {31'b0, rx_ready_o}, 32'h0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 2'd2, 32'h0, rd);

    // Held strobe: exactly one ack and one pop
    for (int i = 0; i < 3; i++) localRxPush($urandom());
    wbs_adr_i = 32'h2;
    wbs_we_i  = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    ack_count = 0;
    first_ack = -1;
    held_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wbs_ack_o) begin
        ack_count++;
        if (first_ack < 0) first_ack = i;
        held_data = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    checkOutput("held_ack_count", ack_count, 32'd1);
    checkOutput("held_ack_latency", first_ack, 32'd0);
    checkOutput("held_data", held_data, rx_q.pop_front());
    tick();
    applyStimulus(1'b0, 2'd1, 32'h0, rd);
    checkOutput("held_rx_count", {24'b0, rd[15:8]}, 32'h2);

    // Flush collides with a TX pop
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd2, $urandom(), rd);
    tx_ready_i = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'h4, rd);
    tx_ready_i = 1'b0;
    checkOutput("flush_tx_valid", {31'b0, tx_valid_o}, 32'h0);
    applyStimulus(1'b0, 2'd1, 32'h0, rd);
    checkOutput("flush_tx_count", {24'b0, rd[23:16]}, 32'h0);

    // Randomized mix against the model
    for (int n = 0; n < 80; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 6))
        0: applyStimulus(1'b1, 2'd2, $urandom(), rd);
        1: applyStimulus(1'b0, 2'd2, 32'h0, rd);
        2: applyStimulus(1'b0, 2'd1, 32'h0, rd);
        3: localRxPush($urandom());
        4: localTxPop();
        5: begin
          d = $urandom() & 32'h73;
          if ($urandom_range(0, 7) == 0) d = d | 32'h4;
          if ($urandom_range(0, 7) == 0) d = d | 32'h8;
          applyStimulus(1'b1, 2'd0, d, rd);
        end
        default: applyStimulus($urandom_range(0, 1) == 1, 2'd3, $urandom(), rd);
      endcase
    end
    applyStimulus(1'b0, 2'd0, 32'h0, rd);
    applyStimulus(1'b0, 2'd1, 32'h0, rd);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
